// File: rtl/serial_word_tx_if.sv
// Handshake bundle for serial_word_tx: parallel word in, serial bit stream out,
// and the per-word remainder report.
//   slave  : the transmitter side (accepts words, drives bits and report)
//   master : the producer/consumer side (offers words, consumes bits)
// Signals:
//   in_valid/in_data/in_ready   parallel word handshake
//   bit_out/bit_valid/bit_last  serial stream, MSB first; bit_ready consumes
//   word_done/word_rem/word_div one-cycle end-of-word report
interface serial_word_tx_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MOD   = 4
);

  localparam int unsigned RW = $clog2(MOD);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  logic             bit_out;
  logic             bit_valid;
  logic             bit_last;
  logic             bit_ready;

  logic             word_done;
  logic [RW-1:0]    word_rem;
  logic             word_div;

  modport slave (
    input  in_valid, in_data, bit_ready,
    output in_ready, bit_out, bit_valid, bit_last,
           word_done, word_rem, word_div
  );

  modport master (
    output in_valid, in_data, bit_ready,
    input  in_ready, bit_out, bit_valid, bit_last,
           word_done, word_rem, word_div
  );

endinterface

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter with running remainder tracking.
// Accepts a WIDTH-bit word, shifts it out MSB first under a per-bit
// valid/ready handshake, and after the last bit issues a one-cycle report of
// the word's value mod MOD and whether it is divisible.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset; aborts any word in flight silently
//   bus  serial_word_tx_if.slave (word input, bit stream, word report)
// Every output is a flop; nothing on the input side reaches an output
// combinationally.
module serial_word_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MOD   = 4
) (
  input  logic             clk,
  input  logic             rst,
  serial_word_tx_if.slave  bus
);

  localparam int unsigned RW = $clog2(MOD);
  localparam int unsigned TW = RW + 1;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic [RW-1:0]    rem_q;

  logic             in_ready_q;
  logic             bit_out_q;
  logic             bit_valid_q;
  logic             bit_last_q;
  logic             word_done_q;
  logic [RW-1:0]    word_rem_q;
  logic             word_div_q;

  logic [TW-1:0]    t_c;
  logic [RW-1:0]    rem_d;

  // Remainder after appending the current bit: (2*rem + bit) mod MOD.
  // rem < MOD, so t < 2*MOD and a single conditional subtract suffices.
  always_comb begin
    t_c   = {rem_q, shreg_q[WIDTH-1]};
    rem_d = RW'(t_c);
    if (t_c >= TW'(MOD)) begin
      rem_d = RW'(t_c - TW'(MOD));
    end
  end

  // FSM, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_last_q  <= 1'b0;
      word_done_q <= 1'b0;
      word_rem_q  <= '0;
      word_div_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q     <= SEND;
            shreg_q     <= bus.in_data;
            cnt_q       <= CW'(WIDTH - 1);
            rem_q       <= '0;
            in_ready_q  <= 1'b0;
            bit_valid_q <= 1'b1;
            bit_out_q   <= bus.in_data[WIDTH-1];
            // WIDTH >= 2, so the first bit is never the last.
            bit_last_q  <= 1'b0;
          end
        end

        SEND: begin
          if (bus.bit_ready) begin
            rem_q   <= rem_d;
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            if (cnt_q == '0) begin
              state_q     <= REPORT;
              bit_valid_q <= 1'b0;
              bit_last_q  <= 1'b0;
              bit_out_q   <= 1'b0;
              word_done_q <= 1'b1;
              word_rem_q  <= rem_d;
              word_div_q  <= (rem_d == '0);
            end else begin
              cnt_q      <= cnt_q - CW'(1);
              // Present the next bit, which is the LSB when cnt reaches 0.
              bit_out_q  <= shreg_q[WIDTH-2];
              bit_last_q <= (cnt_q == CW'(1));
            end
          end
        end

        REPORT: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          word_done_q <= 1'b0;
          word_rem_q  <= '0;
          word_div_q  <= 1'b0;
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          bit_out_q   <= 1'b0;
          bit_valid_q <= 1'b0;
          bit_last_q  <= 1'b0;
          word_done_q <= 1'b0;
          word_rem_q  <= '0;
          word_div_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.bit_last  = bit_last_q;
  assign bus.word_done = word_done_q;
  assign bus.word_rem  = word_rem_q;
  assign bus.word_div  = word_div_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: two instances (MOD=4 and MOD=3) share one stimulus
// stream; expected bits and remainders come from the word value directly.
module tb_serial_word_tx;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             bit_ready;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  serial_word_tx_if #(.WIDTH(WIDTH), .MOD(4)) if4 ();
  serial_word_tx_if #(.WIDTH(WIDTH), .MOD(3)) if3 ();

  assign if4.in_valid  = in_valid;
  assign if4.in_data   = in_data;
  assign if4.bit_ready = bit_ready;
  assign if3.in_valid  = in_valid;
  assign if3.in_data   = in_data;
  assign if3.bit_ready = bit_ready;

  serial_word_tx #(.WIDTH(WIDTH), .MOD(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  serial_word_tx #(.WIDTH(WIDTH), .MOD(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Bit i of word w is on the stream; nothing else may be active.
  task automatic chk_bit(input logic [WIDTH-1:0] w, input int i);
    logic [WIDTH-1:0] wv;
    wv = w;
    chk("bit_valid", {31'd0, if4.bit_valid}, 32'd1);
    chk("bit_out",   {31'd0, if4.bit_out},   {31'd0, wv[WIDTH-1-i]});
    chk("bit_last",  {31'd0, if4.bit_last},  (i == WIDTH-1) ? 32'd1 : 32'd0);
    chk("in_ready_busy", {31'd0, if4.in_ready}, 32'd0);
    chk("word_done_busy", {31'd0, if4.word_done}, 32'd0);
    chk("bit_out_m3", {31'd0, if3.bit_out}, {31'd0, wv[WIDTH-1-i]});
    chk("bit_last_m3", {31'd0, if3.bit_last}, (i == WIDTH-1) ? 32'd1 : 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_in_ready"},  {31'd0, if4.in_ready},  32'd1);
    chk({tag, "_bit_valid"}, {31'd0, if4.bit_valid}, 32'd0);
    chk({tag, "_word_done"}, {31'd0, if4.word_done}, 32'd0);
    chk({tag, "_word_rem"},  {30'd0, if4.word_rem},  32'd0);
    chk({tag, "_word_div"},  {31'd0, if4.word_div},  32'd0);
    chk({tag, "_done_m3"},   {31'd0, if3.word_done}, 32'd0);
    chk({tag, "_rem_m3"},    {30'd0, if3.word_rem},  32'd0);
  endtask

  // Offer word w, stream it out with optional stalls/abort, check the report.
  // keep_valid leaves in_valid high with nxt on in_data once w is accepted.
  task automatic send_word(input logic [WIDTH-1:0] w, input bit keep_valid,
                           input logic [WIDTH-1:0] nxt, input int stall_bit,
                           input int stall_len, input int abort_bit, input bit rnd);
    int waited;
    int sl;
    waited = 0;
    while (!if4.in_ready && waited < 20) begin
      step();
      waited++;
    end
    chk("in_ready_wait", {31'd0, if4.in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = w;
    bit_ready = 1'b1;
    acc_cyc   = cyc + 1;
    step();
    if (keep_valid) in_data = nxt;
    else            in_valid = 1'b0;

    for (int i = 0; i < WIDTH; i++) begin
      if (i == abort_bit) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_quiet("abort");
        chk("abort_bit_last", {31'd0, if4.bit_last}, 32'd0);
        step();
        chk_quiet("abort_next");
        return;
      end
      chk_bit(w, i);
      sl = (i == stall_bit) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < sl; s++) begin
        bit_ready = 1'b0;
        step();
        chk_bit(w, i);
      end
      bit_ready = 1'b1;
      step();
    end

    chk("word_done",  {31'd0, if4.word_done}, 32'd1);
    chk("word_rem",   {30'd0, if4.word_rem},  int'(w) % 4);
    chk("word_div",   {31'd0, if4.word_div},  (int'(w) % 4 == 0) ? 32'd1 : 32'd0);
    chk("report_bit_valid", {31'd0, if4.bit_valid}, 32'd0);
    chk("report_in_ready",  {31'd0, if4.in_ready},  32'd0);
    chk("word_done_m3", {31'd0, if3.word_done}, 32'd1);
    chk("word_rem_m3",  {30'd0, if3.word_rem},  int'(w) % 3);
    chk("word_div_m3",  {31'd0, if3.word_div},  (int'(w) % 3 == 0) ? 32'd1 : 32'd0);
    step();
    chk_quiet("post");
  endtask

  initial begin
    int p;
    logic [WIDTH-1:0] w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    bit_ready = 1'b0;
    repeat (3) step();
    chk_quiet("reset");
    chk("reset_bit_out",  {31'd0, if4.bit_out},  32'd0);
    chk("reset_bit_last", {31'd0, if4.bit_last}, 32'd0);
    rst = 1'b0;
    step();

    // Plain words, including an all-ones word
    send_word(8'h0C, 1'b0, 8'h00, -1, 0, -1, 1'b0);
    send_word(8'hFF, 1'b0, 8'h00, -1, 0, -1, 1'b0);

    // Three-cycle stall on bit 2
    send_word(8'hA5, 1'b0, 8'h00, 2, 3, -1, 1'b0);

    // Back-to-back with in_valid held high
    send_word(8'h04, 1'b1, 8'h07, -1, 0, -1, 1'b0);
    p = acc_cyc;
    send_word(8'h07, 1'b0, 8'h00, -1, 0, -1, 1'b0);
    chk("b2b_period", acc_cyc - p, WIDTH + 2);

    // Reset on the fifth bit, then a clean word
    send_word(8'h10, 1'b0, 8'h00, -1, 0, 4, 1'b0);
    send_word(8'h08, 1'b0, 8'h00, -1, 0, -1, 1'b0);

    // Words that exercise the MOD=3 instance
    send_word(8'd9,  1'b0, 8'h00, -1, 0, -1, 1'b0);
    send_word(8'd10, 1'b0, 8'h00, -1, 0, -1, 1'b0);
    send_word(8'h00, 1'b0, 8'h00, -1, 0, -1, 1'b0);

    // Random words with random backpressure
    for (int k = 0; k < 24; k++) begin
      w = WIDTH'($urandom);
      send_word(w, 1'b0, 8'h00, -1, 0, -1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
